alu_reservation_station: RTL

- Issue-side producer for the integer ALU in the out-of-order core.
- Holds dispatched ALU ops until both source operands are available.
- Snoops the common data bus (CDB) for missing operands.
- Each cycle, issues the oldest ready op to the ALU: in1, in2, shamt, Unsigned, ALUcontrol, plus the destination ROB tag that is carried to writeback.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/alu_reservation_station_if.sv | 59 +++++
 rtl/rs_oldest_select.sv | 31 +++
 rtl/alu_reservation_station.sv | 128 ++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the integer ALU issue path.
// Holds the ALU opcode encodings, the core-wide ROB tag and operand widths,
// the reservation-station entry layout, and the CDB wake-up helper that is
// applied both to stored entries and to ops in their dispatch cycle.
package core_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [2:0]        ctrl;
    logic              uns;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              qj_busy;
    logic              qk_busy;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [TAG_W-1:0]  dest;
  } rs_entry_t;

  // Capture a CDB broadcast into any operand still waiting on that tag.
  function automatic rs_entry_t rs_wakeup(input rs_entry_t         e,
                                          input logic              cv,
                                          input logic [TAG_W-1:0]  ct,
                                          input logic [DATA_W-1:0] cd);
    rs_entry_t r;
    r = e;
    if (e.valid && e.qj_busy && cv && (e.qj == ct)) begin
      r.vj      = cd;
      r.qj_busy = 1'b0;
    end
    if (e.valid && e.qk_busy && cv && (e.qk == ct)) begin
      r.vk      = cd;
      r.qk_busy = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Bus bundle between dispatch/CDB/ALU and the ALU reservation station.
// master: dispatch + CDB + ALU side (drives requests, flush, issue_ready).
// slave : the reservation station (drives disp_ready and the issue payload).
interface alu_reservation_station_if;
  import core_pkg::*;

  logic              flush;

  logic              disp_valid;
  logic              disp_ready;
  logic [2:0]        disp_alu_ctrl;
  logic              disp_unsigned;
  logic [4:0]        disp_shamt;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;
  logic              disp_qj_busy;
  logic              disp_qk_busy;
  logic [TAG_W-1:0]  disp_qj;
  logic [TAG_W-1:0]  disp_qk;
  logic [TAG_W-1:0]  disp_dest;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_in1;
  logic [DATA_W-1:0] issue_in2;
  logic [4:0]        issue_shamt;
  logic              issue_unsigned;
  logic [2:0]        issue_alu_ctrl;
  logic [TAG_W-1:0]  issue_dest;

  modport master (
    output flush,
    output disp_valid, disp_alu_ctrl, disp_unsigned, disp_shamt,
    output disp_vj, disp_vk, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
    output disp_dest,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  issue_valid, issue_in1, issue_in2, issue_shamt, issue_unsigned,
    input  issue_alu_ctrl, issue_dest,
    output issue_ready
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_alu_ctrl, disp_unsigned, disp_shamt,
    input  disp_vj, disp_vk, disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
    input  disp_dest,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output issue_valid, issue_in1, issue_in2, issue_shamt, issue_unsigned,
    output issue_alu_ctrl, issue_dest,
    input  issue_ready
  );

endinterface

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker for the collapsing reservation station.
// Ports: ready (one bit per entry, index 0 oldest) in; grant (one-hot),
// idx (binary index of the grant) and any (some entry ready) out.
// The lowest set index wins.
module rs_oldest_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         ready,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(DEPTH);

  // Scan from the top down so the lowest ready index is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

  assign any = |ready;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing queue of dispatched ALU ops that waits
// for both source operands (snooping the CDB) and issues the oldest ready op.
// Ports: clk, rst_n (synchronous, active-low), bus (slave side of
// alu_reservation_station_if: flush, dispatch, CDB and issue channels).
// Operand and tag widths are core-wide and come from core_pkg.
module alu_reservation_station
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_reservation_station_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  rs_entry_t        ent    [DEPTH];
  rs_entry_t        ent_n  [DEPTH];
  rs_entry_t        ent_up [DEPTH];
  rs_entry_t        disp_ent;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic [CW-1:0]    wpos;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic [IW-1:0]    sel_idx;
  logic             any_ready;
  logic             accept;
  logic             issue_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = ent[i].valid & ~ent[i].qj_busy & ~ent[i].qk_busy;
    end
  end

  rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
    .ready (ready),
    .grant (grant),
    .idx   (sel_idx),
    .any   (any_ready)
  );

  // Full blocks dispatch even when an issue frees a slot the same cycle.
  assign bus.disp_ready = (count < CW'(DEPTH));
  assign bus.issue_valid = any_ready;
  assign issue_fire = any_ready & bus.issue_ready;
  assign accept     = bus.disp_valid & bus.disp_ready;
  assign wpos       = count - CW'(issue_fire);

  // Grant is one-hot, so the payload stays zero when nothing is ready.
  always_comb begin
    bus.issue_in1      = '0;
    bus.issue_in2      = '0;
    bus.issue_shamt    = '0;
    bus.issue_unsigned = 1'b0;
    bus.issue_alu_ctrl = '0;
    bus.issue_dest     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.issue_in1      = ent[i].vj;
        bus.issue_in2      = ent[i].vk;
        bus.issue_shamt    = ent[i].shamt;
        bus.issue_unsigned = ent[i].uns;
        bus.issue_alu_ctrl = ent[i].ctrl;
        bus.issue_dest     = ent[i].dest;
      end
    end
  end

  // Incoming op gets the same CDB compare as stored entries (bypass).
  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.ctrl    = bus.disp_alu_ctrl;
    disp_ent.uns     = bus.disp_unsigned;
    disp_ent.shamt   = bus.disp_shamt;
    disp_ent.vj      = bus.disp_vj;
    disp_ent.vk      = bus.disp_vk;
    disp_ent.qj_busy = bus.disp_qj_busy;
    disp_ent.qk_busy = bus.disp_qk_busy;
    disp_ent.qj      = bus.disp_qj;
    disp_ent.qk      = bus.disp_qk;
    disp_ent.dest    = bus.disp_dest;
    disp_ent = rs_wakeup(disp_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_comb begin
    ent_up[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_up[i] = ent[i + 1];
    end
  end

  // Collapse above the issued slot, then wake, then append the new op at
  // the first free slot after the collapse.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IW'(i) >= sel_idx)) begin
        ent_n[i] = ent_up[i];
      end else begin
        ent_n[i] = ent[i];
      end
      ent_n[i] = rs_wakeup(ent_n[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      if (accept && (CW'(i) == wpos)) begin
        ent_n[i] = disp_ent;
      end
    end
    count_n = count + CW'(accept) - CW'(issue_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= ent_n[i];
      end
      count <= count_n;
    end
  end

endmodule
